end_screen_ctl: RTL and testbench

Frame-synchronous game-flow controller for the display path. Tracks the game phase (menu, play, end screen), captures which player lost, and drives the screen-select and `resoult` code consumed by the end-screen drawing pipeline. All screen changes take effect only at the start of vertical blanking, so no visible frame mixes two screens. It also emits a one-cycle reset pulse to the game logic when a new game starts.

---
 rtl/end_screen_ctl.sv | 186 ++++++++++++++++++
 tb/tb_end_screen_ctl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/end_screen_ctl.sv
// end_screen_ctl
//   Frame-synchronous game-flow controller for the display path. Tracks the
//   game phase (menu, play, end screen), records which player lost, and
//   drives the screen select and result code used by the end-screen drawing
//   pipeline. Screen changes happen only at the start of vertical blanking,
//   so no visible frame shows two screens.
//
// Parameters:
//   HOLD_FRAMES  number of whole frames the end screen is shown before a
//                restart is accepted (1..4095)
//
// Ports:
//   clk         pixel/system clock
//   rst         synchronous, active-high reset
//   vblnk       vertical blanking level from the VGA timing path
//   start       start request level (rising edge used, MENU only)
//   restart     return-to-menu request level (rising edge used, WAIT only)
//   p1_lost     player 1 lost (level or pulse)
//   p2_lost     player 2 lost (level or pulse)
//   screen_sel  00 menu, 01 game, 10 end screen (registered)
//   resoult     00 none, 01 player 1 wins, 10 player 2 wins, 11 draw
//   game_rst    one-cycle pulse resetting the game logic on a new game
//
// Handshake: there is no valid/ready pairing here. Requests are single
// rising edges latched into a sticky flag and consumed by the next frame
// edge; outputs are levels that change only at registered clock edges.

module end_screen_ctl #(
  parameter int HOLD_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       restart,
  input  logic       p1_lost,
  input  logic       p2_lost,
  output logic [1:0] screen_sel,
  output logic [1:0] resoult,
  output logic       game_rst
);

  // PEND is the play screen with a result already latched: the screen
  // keeps showing the game until the next frame boundary.
  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_GAME = 3'd1,
    S_PEND = 3'd2,
    S_HOLD = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  localparam logic [11:0] LAST_FRAME = 12'(HOLD_FRAMES - 1);

  // Current state is kept in a named enum so checkers can bind to it.
  state_t      state;
  state_t      state_n;

  logic        vblnk_d;
  logic        start_d;
  logic        restart_d;
  logic        frame_edge;
  logic        start_edge;
  logic        restart_edge;

  logic        start_req;
  logic        start_req_n;
  logic        restart_req;
  logic        restart_req_n;
  logic [11:0] frame_cnt;
  logic [11:0] frame_cnt_n;

  logic [1:0]  sel_n;
  logic [1:0]  res_n;
  logic        game_rst_n;

  assign frame_edge   = vblnk & ~vblnk_d;
  assign start_edge   = start & ~start_d;
  assign restart_edge = restart & ~restart_d;

  // State register plus registered outputs. The edge-detect delays reset
  // high so a level already asserted at reset release gives no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_MENU;
      vblnk_d     <= 1'b1;
      start_d     <= 1'b1;
      restart_d   <= 1'b1;
      start_req   <= 1'b0;
      restart_req <= 1'b0;
      frame_cnt   <= 12'd0;
      screen_sel  <= 2'b00;
      resoult     <= 2'b00;
      game_rst    <= 1'b0;
    end else begin
      state       <= state_n;
      vblnk_d     <= vblnk;
      start_d     <= start;
      restart_d   <= restart;
      start_req   <= start_req_n;
      restart_req <= restart_req_n;
      frame_cnt   <= frame_cnt_n;
      screen_sel  <= sel_n;
      resoult     <= res_n;
      game_rst    <= game_rst_n;
    end
  end

  // Next-state logic. Request flags only live in their own state, so a
  // request outside that state is dropped rather than remembered. A request
  // edge arriving with the frame edge is folded in via the *_n value.
  always_comb begin
    state_n       = state;
    start_req_n   = 1'b0;
    restart_req_n = 1'b0;
    frame_cnt_n   = frame_cnt;
    case (state)
      S_MENU: begin
        start_req_n = start_req | start_edge;
        if (frame_edge && start_req_n) begin
          state_n     = S_GAME;
          start_req_n = 1'b0;
        end
      end
      S_GAME: begin
        // A loss coinciding with a frame edge still only reaches PEND; the
        // end screen waits for the following frame.
        if (p1_lost || p2_lost) begin
          state_n = S_PEND;
        end
      end
      S_PEND: begin
        if (frame_edge) begin
          state_n     = S_HOLD;
          frame_cnt_n = 12'd0;
        end
      end
      S_HOLD: begin
        if (frame_edge) begin
          if (frame_cnt == LAST_FRAME) begin
            state_n = S_WAIT;
          end else begin
            frame_cnt_n = frame_cnt + 12'd1;
          end
        end
      end
      S_WAIT: begin
        restart_req_n = restart_req | restart_edge;
        if (frame_edge && restart_req_n) begin
          state_n       = S_MENU;
          restart_req_n = 1'b0;
        end
      end
      default: begin
        state_n = S_MENU;
      end
    endcase
  end

  // Output decode, computed from the next state so the registered outputs
  // line up with the state register.
  always_comb begin
    sel_n      = 2'b00;
    res_n      = 2'b00;
    game_rst_n = (state == S_MENU) && (state_n == S_GAME);

    case (state_n)
      S_MENU:         sel_n = 2'b00;
      S_GAME, S_PEND: sel_n = 2'b01;
      S_HOLD, S_WAIT: sel_n = 2'b10;
      default:        sel_n = 2'b00;
    endcase

    // p1_lost means player 2 wins (10); p2_lost means player 1 wins (01).
    // OR-ing keeps repeats by the same player harmless and turns a loss by
    // the other player into a draw.
    case (state)
      S_GAME:  res_n = {p1_lost, p2_lost};
      S_PEND:  res_n = resoult | {p1_lost, p2_lost};
      S_HOLD:  res_n = resoult;
      S_WAIT:  res_n = (state_n == S_MENU) ? 2'b00 : resoult;
      default: res_n = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_end_screen_ctl.sv
// Testbench for end_screen_ctl (HOLD_FRAMES = 3).
// Every output change is an event: the driver pushes the cycle at which a
// change must appear and the new {screen_sel, resoult, game_rst} value; the
// monitor pops on every observed change and compares both.

module tb_end_screen_ctl;

  logic       clk;
  logic       rst;
  logic       vblnk;
  logic       start;
  logic       restart;
  logic       p1_lost;
  logic       p2_lost;
  logic [1:0] screen_sel;
  logic [1:0] resoult;
  logic       game_rst;

  end_screen_ctl #(.HOLD_FRAMES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (vblnk),
    .start     (start),
    .restart   (restart),
    .p1_lost   (p1_lost),
    .p2_lost   (p2_lost),
    .screen_sel(screen_sel),
    .resoult   (resoult),
    .game_rst  (game_rst)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // entry = {cycle[31:0], screen_sel[1:0], resoult[1:0], game_rst}
  logic [36:0] exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic        mon_en = 1'b0;
  logic        first_s = 1'b1;
  logic [4:0]  prev_v = 5'b0;

  always @(negedge clk) begin
    logic [4:0]  cur;
    logic [36:0] e;
    if (mon_en) begin
      cur = {screen_sel, resoult, game_rst};
      if (first_s || cur != prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change: cycle %0d sel=%b res=%b rst=%b, required no change",
                   cyc, cur[4:3], cur[2:1], cur[0]);
        end else begin
          e = exp_q.pop_front();
          if (e[36:5] != 32'(cyc) || e[4:0] != cur) begin
            $display("FAIL event_%0d: got cycle %0d sel=%b res=%b rst=%b, required cycle %0d sel=%b res=%b rst=%b",
                     checks, cyc, cur[4:3], cur[2:1], cur[0],
                     e[36:5], e[4:3], e[2:1], e[0]);
          end else begin
            passes++;
          end
        end
      end
      prev_v  = cur;
      first_s = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect an output change dc cycles after the current cycle.
  task automatic expect_chg(input int dc, input logic [1:0] sel,
                            input logic [1:0] res, input logic grst);
    exp_q.push_back({32'(cyc + dc), sel, res, grst});
  endtask

  task automatic vpulse();
    vblnk = 1'b1;
    tick(3);
    vblnk = 1'b0;
    tick(3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(2);
  endtask

  // Start request then frame edge: GAME with a one-cycle game_rst.
  task automatic new_game();
    pulse_start();
    expect_chg(1, 2'b01, 2'b00, 1'b1);
    expect_chg(2, 2'b01, 2'b00, 1'b0);
    vpulse();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; vblnk = 1'b1; start = 1'b1; restart = 1'b1;
    p1_lost = 1'b0; p2_lost = 1'b0;
    tick(2);

    // reset values with all request levels high
    mon_en = 1'b1;
    expect_chg(0, 2'b00, 2'b00, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(3);
    // a vblnk rise while start is merely held high must not start a game
    vblnk = 1'b0;
    tick(3);
    vblnk = 1'b1;
    tick(3);
    start = 1'b0; restart = 1'b0; vblnk = 1'b0;
    tick(3);

    // start then frame edge
    new_game();

    // single p2 loss: player 1 wins, end screen at next frame edge
    expect_chg(1, 2'b01, 2'b01, 1'b0);
    p2_lost = 1'b1;
    tick(1);
    p2_lost = 1'b0;
    tick(3);
    expect_chg(1, 2'b10, 2'b01, 1'b0);
    vpulse();

    // HOLD of 3 frames; restart during HOLD is dropped
    pulse_restart();
    vpulse();                 // frame 1
    vpulse();                 // frame 2
    pulse_restart();          // still HOLD: ignored
    vpulse();                 // frame 3 -> WAIT, no visible change
    vpulse();                 // no pending restart -> stays
    pulse_restart();
    expect_chg(1, 2'b00, 2'b00, 1'b0);
    vpulse();

    // p1 loss, p2 loss 3 cycles later -> 10 then 11; repeat p1 is harmless
    new_game();
    expect_chg(1, 2'b01, 2'b10, 1'b0);
    p1_lost = 1'b1;
    tick(1);
    p1_lost = 1'b0;
    tick(2);
    expect_chg(1, 2'b01, 2'b11, 1'b0);
    p2_lost = 1'b1;
    tick(1);
    p2_lost = 1'b0;
    tick(2);
    p1_lost = 1'b1;
    tick(1);
    p1_lost = 1'b0;
    tick(2);
    expect_chg(1, 2'b10, 2'b11, 1'b0);
    vpulse();

    // reset during HOLD
    vpulse();
    expect_chg(1, 2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);

    // fresh game, both players lose in one cycle -> draw directly
    new_game();
    expect_chg(1, 2'b01, 2'b11, 1'b0);
    p1_lost = 1'b1; p2_lost = 1'b1;
    tick(1);
    p1_lost = 1'b0; p2_lost = 1'b0;
    tick(2);
    expect_chg(1, 2'b10, 2'b11, 1'b0);
    vpulse();
    vpulse();
    vpulse();
    vpulse();                 // third HOLD frame -> WAIT
    // restart edge and frame edge in the same cycle
    restart = 1'b1;
    vblnk   = 1'b1;
    expect_chg(1, 2'b00, 2'b00, 1'b0);
    tick(1);
    restart = 1'b0;
    tick(2);
    vblnk = 1'b0;
    tick(3);

    // start edge and frame edge in the same cycle
    start = 1'b1;
    vblnk = 1'b1;
    expect_chg(1, 2'b01, 2'b00, 1'b1);
    expect_chg(2, 2'b01, 2'b00, 1'b0);
    tick(1);
    start = 1'b0;
    tick(2);
    vblnk = 1'b0;
    tick(3);

    // loss coincident with frame edge: PEND only, end screen one frame later
    p1_lost = 1'b1;
    vblnk   = 1'b1;
    expect_chg(1, 2'b01, 2'b10, 1'b0);
    tick(1);
    p1_lost = 1'b0;
    tick(2);
    vblnk = 1'b0;
    tick(3);
    expect_chg(1, 2'b10, 2'b10, 1'b0);
    vpulse();

    tick(5);

    // ---------------- final report ----------------
    while (exp_q.size() > 0) begin
      logic [36:0] e;
      e = exp_q.pop_front();
      checks++;
      $display("FAIL missing_event: got no change, required cycle %0d sel=%b res=%b rst=%b",
               e[36:5], e[4:3], e[2:1], e[0]);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
